pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 16 +
 rtl/pipe_ctrl.sv | 99 +++++++++
 tb/tb_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Data-bus handshake seen by the pipeline controller.
// The MEM stage raises mem_req; the bus answers with mem_ack.
interface pipe_ctrl_if;
  logic mem_req;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_ack
  );

  modport slave (
    input mem_req,
    input mem_ack
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with bus timeout,
// load-use interlock, redirect flushes and a stall cycle counter.
module pipe_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_ren,
  input  logic        id_rs2_ren,
  input  logic [4:0]  ex_w_addr,
  input  logic        ex_w_ena,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  pipe_ctrl_if.slave  mem,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_ERR  = 2'd2
  } mstate_t;

  mstate_t     state;
  logic [7:0]  tmo_cnt;
  logic [31:0] stall_cnt_q;

  logic mem_hold;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic redirect;
  logic interlock;

  always_comb begin
    mem_hold = 1'b0;
    unique case (state)
      M_IDLE:  mem_hold = mem.mem_req & ~mem.mem_ack;
      M_WAIT:  mem_hold = ~mem.mem_ack;
      default: mem_hold = 1'b1;
    endcase
  end

  assign rs1_hit = id_rs1_ren & (id_rs1_addr == ex_w_addr);
  assign rs2_hit = id_rs2_ren & (id_rs2_addr == ex_w_addr);

  assign load_use = ex_is_load & ex_w_ena
                  & (ex_w_addr != 5'd0)
                  & (rs1_hit | rs2_hit);

  // A frozen EX keeps ex_redirect asserted, so no pending flag is needed.
  assign redirect  = ~mem_hold & ex_redirect;
  assign interlock = ~mem_hold & ~ex_redirect & load_use;

  assign stall_mem = mem_hold;
  assign stall_ex  = mem_hold;
  assign stall_id  = mem_hold | interlock;
  assign stall_if  = mem_hold | interlock;
  assign flush_id  = redirect;
  assign flush_ex  = redirect | interlock;

  assign mem_err   = (state == M_ERR);
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= M_IDLE;
      tmo_cnt     <= 8'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, stall_if};
      unique case (state)
        M_IDLE: begin
          if (mem.mem_req && !mem.mem_ack) begin
            state   <= M_WAIT;
            tmo_cnt <= 8'd0;
          end
        end
        M_WAIT: begin
          if (mem.mem_ack)
            state <= M_IDLE;
          else if (tmo_cnt == 8'hFF)
            state <= M_ERR;
          else
            tmo_cnt <= tmo_cnt + 8'd1;
        end
        default: state <= M_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for the combinational
// hazard logic plus sequences for wait, redirect, timeout and wrap.
module tb_pipe_ctrl;

  logic        clock;
  logic        reset;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rs1_ren;
  logic        id_rs2_ren;
  logic [4:0]  ex_w_addr;
  logic        ex_w_ena;
  logic        ex_is_load;
  logic        ex_redirect;
  logic        stall_if;
  logic        stall_id;
  logic        stall_ex;
  logic        stall_mem;
  logic        flush_id;
  logic        flush_ex;
  logic        mem_err;
  logic [31:0] stall_cnt;

  pipe_ctrl_if mem_if ();

  pipe_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_ren  (id_rs1_ren),
    .id_rs2_ren  (id_rs2_ren),
    .ex_w_addr   (ex_w_addr),
    .ex_w_ena    (ex_w_ena),
    .ex_is_load  (ex_is_load),
    .ex_redirect (ex_redirect),
    .mem         (mem_if.slave),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .stall_mem   (stall_mem),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       r1;
    logic       r2;
    logic [4:0] wa;
    logic       we;
    logic       ld;
    logic       rd;
    logic       mq;
    logic       ma;
    logic [5:0] exp;
  } vec_t;

  vec_t        vecs [12];
  int          checks;
  int          errors;
  logic [31:0] cnt_model;

  function automatic logic [5:0] outs();
    return {stall_if, stall_id, stall_ex,
            stall_mem, flush_id, flush_ex};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1_addr    = 5'd0;
    id_rs2_addr    = 5'd0;
    id_rs1_ren     = 1'b0;
    id_rs2_ren     = 1'b0;
    ex_w_addr      = 5'd0;
    ex_w_ena       = 1'b0;
    ex_is_load     = 1'b0;
    ex_redirect    = 1'b0;
    mem_if.mem_req = 1'b0;
    mem_if.mem_ack = 1'b0;
  endtask

  task automatic set_hazard();
    ex_is_load  = 1'b1;
    ex_w_ena    = 1'b1;
    ex_w_addr   = 5'd5;
    id_rs1_ren  = 1'b1;
    id_rs1_addr = 5'd5;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // exp order: stall_if stall_id stall_ex stall_mem flush_id flush_ex
  initial begin
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110001};
    vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[3]  = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110001};
    vecs[4]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000011};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000011};
    vecs[9]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'b110001};
    vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
    vecs[11] = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_outs", {26'd0, outs()}, 32'd0);
    chk("reset_err", {31'd0, mem_err}, 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);

    // Combinational vector table, stall_cnt tracked across vectors
    cnt_model = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk($sformatf("vec%0d_cnt", i), stall_cnt, cnt_model);
      id_rs1_addr    = vecs[i].rs1;
      id_rs2_addr    = vecs[i].rs2;
      id_rs1_ren     = vecs[i].r1;
      id_rs2_ren     = vecs[i].r2;
      ex_w_addr      = vecs[i].wa;
      ex_w_ena       = vecs[i].we;
      ex_is_load     = vecs[i].ld;
      ex_redirect    = vecs[i].rd;
      mem_if.mem_req = vecs[i].mq;
      mem_if.mem_ack = vecs[i].ma;
      #1;
      chk($sformatf("vec%0d_outs", i), {26'd0, outs()},
          {26'd0, vecs[i].exp});
      cnt_model = cnt_model + {31'd0, vecs[i].exp[5]};
    end
    @(negedge clock);
    idle_inputs();
    chk("table_cnt", stall_cnt, cnt_model);

    // Memory wait: three stalled cycles, then ack releases
    do_reset();
    mem_if.mem_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("wait%0d_outs", k), {26'd0, outs()},
          {26'd0, 6'b111100});
      @(negedge clock);
    end
    mem_if.mem_ack = 1'b1;
    #1;
    chk("wait_ack_outs", {26'd0, outs()}, 32'd0);
    @(negedge clock);
    idle_inputs();
    #1;
    chk("wait_cnt", stall_cnt, 32'd3);
    chk("wait_err", {31'd0, mem_err}, 32'd0);
    mem_if.mem_req = 1'b1;
    mem_if.mem_ack = 1'b1;
    #1;
    chk("wait_back_idle", {26'd0, outs()}, 32'd0);

    // Redirect held during a memory wait flushes only once ack arrives
    @(negedge clock);
    idle_inputs();
    set_hazard();
    ex_redirect    = 1'b1;
    mem_if.mem_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("rdw%0d_outs", k), {26'd0, outs()},
          {26'd0, 6'b111100});
      @(negedge clock);
    end
    mem_if.mem_ack = 1'b1;
    #1;
    chk("rdw_flush", {26'd0, outs()}, {26'd0, 6'b000011});
    @(negedge clock);
    idle_inputs();

    // Bus timeout: 1 idle-hold cycle plus 256 wait cycles reach M_ERR
    do_reset();
    mem_if.mem_req = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      @(negedge clock);
      if (k == 256)
        chk("tmo_not_yet", {31'd0, mem_err}, 32'd0);
    end
    #1;
    chk("tmo_err", {31'd0, mem_err}, 32'd1);
    chk("tmo_cnt", stall_cnt, 32'd257);
    mem_if.mem_req = 1'b0;
    mem_if.mem_ack = 1'b1;
    ex_redirect    = 1'b1;
    #1;
    chk("err_outs", {26'd0, outs()}, {26'd0, 6'b111100});
    repeat (10) @(negedge clock);
    #1;
    chk("err_sticky", {31'd0, mem_err}, 32'd1);
    chk("err_cnt", stall_cnt, 32'd267);
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    #1;
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_outs", {26'd0, outs()}, 32'd0);
    reset = 1'b0;

    // Counter wrap under a sustained load-use stall
    @(negedge clock);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    set_hazard();
    #1;
    chk("wrap_start", stall_cnt, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      chk($sformatf("wrap%0d_stall", k), {26'd0, outs()},
          {26'd0, 6'b110001});
      chk($sformatf("wrap%0d_cnt", k), stall_cnt,
          32'hFFFF_FFFF + k);
    end
    @(negedge clock);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
